// File: rtl/spi_pkg.sv
// Shared definitions for the SPI configuration master: FSM encoding and SPI mode helpers.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP,
        ST_DONE
    } spi_state_t;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    function automatic logic [1:0] spi_mode(input logic cpol, input logic cpha);
        case ({cpol, cpha})
            2'b00:   return MODE0;
            2'b01:   return MODE1;
            2'b10:   return MODE2;
            default: return MODE3;
        endcase
    endfunction

    // CPHA=0 modes capture on the leading edge and launch the next bit on the trailing edge.
    function automatic logic samples_on_lead(input logic [1:0] mode);
        return (mode == MODE0) || (mode == MODE2);
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SPI clock divider: toggles spi_clk every CLK_DIV cycles while enabled and flags the
// cycle whose closing sclk edge produces a leading or trailing spi_clk edge.
module spi_clk_gen #(
    parameter int CLK_DIV = 1,
    parameter int CPOL    = 0
) (
    input  logic sclk,
    input  logic rst,
    input  logic i_en,
    output logic o_spi_clk,
    output logic o_lead_stb,
    output logic o_trail_stb
);

    localparam int               DIV_W    = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic             CLK_IDLE = (CPOL != 0);

    logic [DIV_W-1:0] r_div;
    logic             r_spi_clk;
    logic             w_tick;

    assign w_tick      = i_en && (r_div == DIV_LAST);
    assign o_lead_stb  = w_tick && (r_spi_clk == CLK_IDLE);
    assign o_trail_stb = w_tick && (r_spi_clk != CLK_IDLE);
    assign o_spi_clk   = r_spi_clk;

    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_div     <= '0;
            r_spi_clk <= CLK_IDLE;
        end else if (!i_en) begin
            r_div     <= '0;
            r_spi_clk <= CLK_IDLE;
        end else if (w_tick) begin
            r_div     <= '0;
            r_spi_clk <= ~r_spi_clk;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

endmodule

// File: rtl/spi_cfg_master.sv
// SPI configuration master: streams NUM_WORDS ROM words to an SPI slave, one CS frame per
// word, and returns the spi_sdo read-back of each frame.
module spi_cfg_master
    import spi_pkg::*;
#(
    parameter int WORD_W    = 16,
    parameter int NUM_WORDS = 32,
    parameter int ADDR_W    = 5,
    parameter int CLK_DIV   = 1,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int GAP_CYC   = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              work_en,
    output logic [ADDR_W-1:0] word_addr,
    input  logic [WORD_W-1:0] word_data,
    output logic              spi_clk,
    output logic              spi_sdi,
    output logic              spi_csn,
    input  logic              spi_sdo,
    output logic [WORD_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic              conf_end
);

    localparam logic             LEAD_SAMPLE = samples_on_lead(spi_mode(CPOL != 0, CPHA != 0));
    localparam int               CNT_W       = $clog2(((CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC) + 1);
    localparam logic [CNT_W-1:0] DIV_LAST    = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYC - 1);
    localparam int               BIT_W       = $clog2(WORD_W);
    localparam logic [BIT_W-1:0] BIT_TOP     = BIT_W'(WORD_W - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_WORDS - 1);

    spi_state_t        r_state;
    logic [ADDR_W-1:0] r_index;
    logic [CNT_W-1:0]  r_cnt;
    logic [BIT_W-1:0]  r_bit;
    logic [WORD_W-1:0] r_tx;
    logic [WORD_W-1:0] r_rx;
    logic [ADDR_W-1:0] r_word_addr;
    logic              r_sdi;
    logic              r_csn;
    logic [WORD_W-1:0] r_rd_data;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_rd_valid;
    logic              r_conf_end;

    logic w_lead;
    logic w_trail;
    logic w_launch;
    logic w_sample;

    function automatic logic head_bit(input logic [WORD_W-1:0] w);
        return (MSB_FIRST != 0) ? w[WORD_W-1] : w[0];
    endfunction

    function automatic logic [WORD_W-1:0] shift_in(input logic [WORD_W-1:0] w, input logic b);
        return (MSB_FIRST != 0) ? {w[WORD_W-2:0], b} : {b, w[WORD_W-1:1]};
    endfunction

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV),
        .CPOL    (CPOL)
    ) u_clk_gen (
        .sclk        (sclk),
        .rst         (rst),
        .i_en        (r_state == ST_SHIFT),
        .o_spi_clk   (spi_clk),
        .o_lead_stb  (w_lead),
        .o_trail_stb (w_trail)
    );

    assign w_launch  = LEAD_SAMPLE ? w_trail : w_lead;
    assign w_sample  = LEAD_SAMPLE ? w_lead  : w_trail;

    assign word_addr = r_word_addr;
    assign spi_sdi   = r_sdi;
    assign spi_csn   = r_csn;
    assign rd_data   = r_rd_data;
    assign rd_addr   = r_rd_addr;
    assign rd_valid  = r_rd_valid;
    assign conf_end  = r_conf_end;

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_index     <= '0;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_word_addr <= '0;
            r_sdi       <= 1'b0;
            r_csn       <= 1'b1;
            r_rd_data   <= '0;
            r_rd_addr   <= '0;
            r_rd_valid  <= 1'b0;
            r_conf_end  <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            if (w_sample)
                r_rx <= shift_in(r_rx, spi_sdo);

            case (r_state)
                ST_IDLE: begin
                    if (work_en) begin
                        r_index     <= '0;
                        r_word_addr <= '0;
                        r_state     <= ST_FETCH;
                    end
                end
                ST_FETCH: r_state <= ST_LOAD;
                ST_LOAD: begin
                    r_csn   <= 1'b0;
                    r_cnt   <= '0;
                    r_bit   <= BIT_TOP;
                    r_state <= ST_SETUP;
                    // CPHA=0 presents the first bit before the first edge; CPHA=1 launches it on that edge.
                    if (LEAD_SAMPLE) begin
                        r_sdi <= head_bit(word_data);
                        r_tx  <= shift_in(word_data, 1'b0);
                    end else begin
                        r_sdi <= 1'b0;
                        r_tx  <= word_data;
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == DIV_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (w_launch) begin
                        r_sdi <= head_bit(r_tx);
                        r_tx  <= shift_in(r_tx, 1'b0);
                    end
                    if (w_trail) begin
                        if (r_bit == '0)
                            r_state <= ST_HOLD;
                        else
                            r_bit <= r_bit - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == DIV_LAST) begin
                        r_cnt      <= '0;
                        r_rd_data  <= r_rx;
                        r_rd_addr  <= r_index;
                        r_rd_valid <= 1'b1;
                        r_csn      <= 1'b1;
                        r_sdi      <= 1'b0;
                        r_state    <= ST_GAP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt <= '0;
                        if (!work_en) begin
                            r_state <= ST_IDLE;
                        end else if (r_index == LAST_ADDR) begin
                            r_conf_end <= 1'b1;
                            r_state    <= ST_DONE;
                        end else begin
                            r_index     <= r_index + 1'b1;
                            r_word_addr <= r_index + 1'b1;
                            r_state     <= ST_FETCH;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!work_en) begin
                        r_conf_end <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cfg_master.sv
// Bench for spi_cfg_master: five instances covering all SPI modes, two dividers and both
// bit orders, each with a sync ROM, sdo loopback and an SPI slave monitor.
module tb_spi_cfg_master;

    localparam int NDUT = 5;
    localparam int CFG_CPOL [NDUT] = '{0, 0, 1, 1, 0};
    localparam int CFG_CPHA [NDUT] = '{0, 1, 0, 1, 0};
    localparam int CFG_DIV  [NDUT] = '{1, 3, 3, 3, 1};
    localparam int CFG_MSB  [NDUT] = '{1, 1, 1, 1, 0};

    localparam int S_FRAMES = 0, S_RVALID = 1, S_DATA_ERR = 2, S_RD_ERR = 3, S_STABLE_ERR = 4;
    localparam int S_IDLE_ERR = 5, S_PERIOD_ERR = 6, S_MAXADDR = 7, S_SEQ0 = 8, NSTAT = 9;

    typedef struct {
        int dut;
        int sel;
        int exp;
    } vec_t;

    logic sclk    = 1'b0;
    logic rst     = 1'b0;
    logic work_en = 1'b0;
    logic mon_clr = 1'b1;
    int   cyc     = 0;
    int   n_cmp   = 0;
    int   n_fail  = 0;

    logic [NDUT-1:0][4:0]  word_addr;
    logic [NDUT-1:0][4:0]  rd_addr;
    logic [NDUT-1:0][15:0] rd_data;
    logic [NDUT-1:0]       spi_clk, spi_sdi, spi_csn, rd_valid, conf_end;
    wire  [31:0]           stat [NDUT][NSTAT];

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc++;

    function automatic logic [15:0] rom_word(input int g, input int a);
        if (g == 4 && a == 0) return 16'hA5C3;
        return 16'(32'h8001 + a);
    endfunction

    function automatic string stat_name(input int s);
        case (s)
            S_FRAMES:     return "frames";
            S_RVALID:     return "rd_valid_count";
            S_DATA_ERR:   return "slave_word_errors";
            S_RD_ERR:     return "readback_errors";
            S_STABLE_ERR: return "sdi_unstable_at_sample";
            S_IDLE_ERR:   return "spi_clk_idle_errors";
            S_PERIOD_ERR: return "timing_errors";
            S_MAXADDR:    return "max_word_addr";
            default:      return "first_frame_bit_order";
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sclk);
    endtask

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int P_CPOL = CFG_CPOL[g];
        localparam int P_CPHA = CFG_CPHA[g];
        localparam int P_DIV  = CFG_DIV[g];
        localparam int P_MSB  = CFG_MSB[g];
        localparam int WORD_PERIOD = 2 + P_DIV * (2 * 16 + 2) + 2;

        logic [15:0] rom_q;

        spi_cfg_master #(
            .WORD_W(16), .NUM_WORDS(32), .ADDR_W(5), .CLK_DIV(P_DIV),
            .CPOL(P_CPOL), .CPHA(P_CPHA), .GAP_CYC(2), .MSB_FIRST(P_MSB)
        ) u_dut (
            .sclk      (sclk),
            .rst       (rst),
            .work_en   (work_en),
            .word_addr (word_addr[g]),
            .word_data (rom_q),
            .spi_clk   (spi_clk[g]),
            .spi_sdi   (spi_sdi[g]),
            .spi_csn   (spi_csn[g]),
            .spi_sdo   (spi_sdi[g]),
            .rd_data   (rd_data[g]),
            .rd_addr   (rd_addr[g]),
            .rd_valid  (rd_valid[g]),
            .conf_end  (conf_end[g])
        );

        always @(posedge sclk) rom_q <= rom_word(g, int'(word_addr[g]));

        int frames = 0, rvalid = 0, data_err = 0, rd_err = 0, stable_err = 0;
        int idle_err = 0, period_err = 0, max_addr = 0;
        int nbits = 0, nedges = 0, last_lead = 0, last_fall = 0;
        bit have_lead = 0, have_fall = 0, lead;
        logic prev_clk = 1'(P_CPOL), prev_sdi = 1'b0, prev_csn = 1'b1;
        logic [15:0] shreg = '0, seq0 = '0;

        always @(negedge sclk) begin
            if (mon_clr) begin
                frames = 0; rvalid = 0; data_err = 0; rd_err = 0; stable_err = 0;
                idle_err = 0; period_err = 0; max_addr = 0; have_fall = 0; seq0 = '0;
            end else begin
                if (int'(word_addr[g]) > max_addr) max_addr = int'(word_addr[g]);
                if (spi_csn[g] && spi_clk[g] != 1'(P_CPOL)) idle_err++;
                if (prev_csn && !spi_csn[g]) begin
                    if (have_fall && (cyc - last_fall) != WORD_PERIOD) period_err++;
                    have_fall = 1; last_fall = cyc; nbits = 0; nedges = 0; have_lead = 0;
                end
                if (!spi_csn[g] && spi_clk[g] != prev_clk) begin
                    lead = (prev_clk == 1'(P_CPOL));
                    nedges++;
                    if (lead) begin
                        if (have_lead && (cyc - last_lead) != 2 * P_DIV) period_err++;
                        have_lead = 1; last_lead = cyc;
                    end
                    if (lead == (P_CPHA == 0)) begin
                        if (spi_sdi[g] != prev_sdi) stable_err++;
                        if (frames == 0 && nbits < 16) seq0[nbits] = spi_sdi[g];
                        shreg = (P_MSB != 0) ? {shreg[14:0], spi_sdi[g]} : {spi_sdi[g], shreg[15:1]};
                        nbits++;
                    end
                end
                if (!prev_csn && spi_csn[g]) begin
                    if (nbits != 16 || nedges != 32 || shreg != rom_word(g, frames)) data_err++;
                    frames++;
                end
                if (rd_valid[g]) begin
                    if (int'(rd_addr[g]) != rvalid || rd_data[g] != rom_word(g, rvalid)) rd_err++;
                    rvalid++;
                end
            end
            prev_clk = spi_clk[g];
            prev_sdi = spi_sdi[g];
            prev_csn = spi_csn[g];
        end

        assign stat[g][S_FRAMES]     = frames;
        assign stat[g][S_RVALID]     = rvalid;
        assign stat[g][S_DATA_ERR]   = data_err;
        assign stat[g][S_RD_ERR]     = rd_err;
        assign stat[g][S_STABLE_ERR] = stable_err;
        assign stat[g][S_IDLE_ERR]   = idle_err;
        assign stat[g][S_PERIOD_ERR] = period_err;
        assign stat[g][S_MAXADDR]    = max_addr;
        assign stat[g][S_SEQ0]       = 32'(seq0);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[$];
        int          order [16] = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1};
        logic [15:0] seq_exp;
        int          n, bad;

        for (int k = 0; k < 16; k++) seq_exp[k] = order[k][0];
        for (int d = 0; d < NDUT; d++) begin
            tbl.push_back('{d, S_FRAMES, 32});
            tbl.push_back('{d, S_RVALID, 32});
            tbl.push_back('{d, S_DATA_ERR, 0});
            tbl.push_back('{d, S_RD_ERR, 0});
            tbl.push_back('{d, S_STABLE_ERR, 0});
            tbl.push_back('{d, S_IDLE_ERR, 0});
            tbl.push_back('{d, S_PERIOD_ERR, 0});
            tbl.push_back('{d, S_MAXADDR, 31});
        end
        tbl.push_back('{4, S_SEQ0, int'(seq_exp)});

        // Reset values
        #1 rst = 1'b1;
        tick(2);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("reset_spi_clk%0d", d), 32'(spi_clk[d]), 32'(CFG_CPOL[d]));
            check($sformatf("reset_csn%0d", d), 32'(spi_csn[d]), 1);
            check($sformatf("reset_sdi%0d", d), 32'(spi_sdi[d]), 0);
            check($sformatf("reset_word_addr%0d", d), 32'(word_addr[d]), 0);
            check($sformatf("reset_rd_valid%0d", d), 32'(rd_valid[d]), 0);
            check($sformatf("reset_conf_end%0d", d), 32'(conf_end[d]), 0);
        end

        // Full run on every configuration
        rst = 1'b0; mon_clr = 1'b0; work_en = 1'b1;
        n = 0;
        while (conf_end != '1 && n < 6000) begin tick(1); n++; end
        check("full_run_done_in_budget", 32'(conf_end == '1), 1);
        tick(2);
        foreach (tbl[i])
            check($sformatf("dut%0d_%s", tbl[i].dut, stat_name(tbl[i].sel)),
                  stat[tbl[i].dut][tbl[i].sel], 32'(tbl[i].exp));

        // DONE held with work_en high: no frames, conf_end stays
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            tick(1);
            if (spi_csn != '1) bad++;
        end
        check("done_csn_quiet", bad, 0);
        check("done_conf_end_held", 32'(conf_end), 32'({NDUT{1'b1}}));
        check("done_frames_dut0", stat[0][S_FRAMES], 32);
        work_en = 1'b0;
        tick(1);
        check("conf_end_clear", 32'(conf_end), 0);

        // work_en drops during word 5
        tick(2);
        mon_clr = 1'b1; tick(1); mon_clr = 1'b0;
        work_en = 1'b1;
        n = 0;
        while (!(stat[0][S_FRAMES] == 5 && !spi_csn[0]) && n < 1000) begin tick(1); n++; end
        check("word5_started_in_budget", 32'(n < 1000), 1);
        work_en = 1'b0;
        tick(400);
        check("abort_frames", stat[0][S_FRAMES], 6);
        check("abort_rd_valid_count", stat[0][S_RVALID], 6);
        check("abort_data_errors", stat[0][S_DATA_ERR], 0);
        check("abort_conf_end", 32'(conf_end[0]), 0);
        check("abort_word_addr_last", 32'(word_addr[0]), 5);
        work_en = 1'b1;
        tick(1);
        check("restart_word_addr", 32'(word_addr[0]), 0);

        // Reset pulse mid-SHIFT
        n = 0;
        while (spi_csn[0] && n < 100) begin tick(1); n++; end
        check("restart_csn_low_in_budget", 32'(spi_csn[0]), 0);
        tick(6);
        rst = 1'b1; mon_clr = 1'b1;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("midrst_csn%0d", d), 32'(spi_csn[d]), 1);
            check($sformatf("midrst_spi_clk%0d", d), 32'(spi_clk[d]), 32'(CFG_CPOL[d]));
            check($sformatf("midrst_rd_valid%0d", d), 32'(rd_valid[d]), 0);
        end
        tick(3);
        check("midrst_spi_clk_still_idle", 32'(spi_clk[2]), 1);
        rst = 1'b0; mon_clr = 1'b0;
        n = 0;
        while (!rd_valid[0] && n < 200) begin tick(1); n++; end
        check("postrst_rd_valid_in_budget", 32'(rd_valid[0]), 1);
        check("postrst_rd_addr", 32'(rd_addr[0]), 0);
        check("postrst_rd_data", 32'(rd_data[0]), 32'h8001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
